instruction_fetch: RTL and testbench

Fetch stage of the MIPS datapath, sitting directly upstream of the instruction memory (`im`). It holds the program counter, drives the word address into `im`, and captures the returned instruction into the IF/ID pipeline register for the decoder. It handles stall, branch/jump redirect with wrong-path flush, out-of-range fetch detection and a retired-fetch counter.

---
 rtl/instruction_fetch_if.sv | 33 +++
 rtl/instruction_fetch.sv | 90 +++++++++
 tb/tb_instruction_fetch.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Bus bundle between the fetch stage and its environment: hazard/redirect
// controls in, instruction-memory word address out / data in, and the
// IF/ID pipeline register plus status outputs toward the decoder.
interface instruction_fetch_if #(
    parameter int IM_ADDRESS_WIDTH  = 6,
    parameter int INSTRUCTION_WIDTH = 32
);
    logic                          stall;
    logic                          redirect;
    logic [31:0]                   redirect_pc;
    logic [IM_ADDRESS_WIDTH-1:0]   im_addr;
    logic [INSTRUCTION_WIDTH-1:0]  im_q;
    logic [31:0]                   pc;
    logic [INSTRUCTION_WIDTH-1:0]  if_id_instr;
    logic [31:0]                   if_id_pc4;
    logic                          if_id_valid;
    logic                          fetch_fault;
    logic [31:0]                   fetch_count;

    // Fetch stage side.
    modport master (
        input  stall, redirect, redirect_pc, im_q,
        output im_addr, pc, if_id_instr, if_id_pc4, if_id_valid,
               fetch_fault, fetch_count
    );

    // Environment side (hazard unit, branch logic, instruction memory, decoder).
    modport slave (
        output stall, redirect, redirect_pc, im_q,
        input  im_addr, pc, if_id_instr, if_id_pc4, if_id_valid,
               fetch_fault, fetch_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: program counter, word address into instruction memory,
// IF/ID pipeline register, redirect flush, stall hold, sticky out-of-range
// fault and a count of instructions latched valid.
module instruction_fetch #(
    parameter int          IM_ADDRESS_WIDTH  = 6,
    parameter int          INSTRUCTION_WIDTH = 32,
    parameter logic [31:0] RESET_PC          = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus
);

    localparam int          HI_W             = 32 - IM_ADDRESS_WIDTH - 2;
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    // A PC is fetchable only when every bit above the memory word index is clear.
    function automatic logic pc_in_range(input logic [31:0] addr);
        return (addr[31:IM_ADDRESS_WIDTH+2] == {HI_W{1'b0}});
    endfunction

    logic [31:0]                  pc_q,          pc_d;
    logic [INSTRUCTION_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
    logic [31:0]                  if_id_pc4_q,   if_id_pc4_d;
    logic                         if_id_valid_q, if_id_valid_d;
    logic                         fetch_fault_q, fetch_fault_d;
    logic [31:0]                  fetch_count_q, fetch_count_d;
    logic [31:0]                  pc_plus4_s;

    assign pc_plus4_s = pc_q + 32'd4;

    // Next-state selection: redirect beats stall, stall beats the range check.
    always_comb begin
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        fetch_fault_d = fetch_fault_q;
        fetch_count_d = fetch_count_q;
        if (bus.redirect) begin
            // Wrong-path instruction in IF/ID is squashed; the target is fetched next.
            pc_d          = {bus.redirect_pc[31:2], 2'b00};
            if_id_instr_d = {INSTRUCTION_WIDTH{1'b0}};
            if_id_pc4_d   = 32'd0;
            if_id_valid_d = 1'b0;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (!pc_in_range(pc_q)) begin
            // PC is parked so it never wraps; decoder sees bubbles until redirected.
            if_id_instr_d = {INSTRUCTION_WIDTH{1'b0}};
            if_id_pc4_d   = 32'd0;
            if_id_valid_d = 1'b0;
            fetch_fault_d = 1'b1;
        end else begin
            pc_d          = pc_plus4_s;
            if_id_instr_d = bus.im_q;
            if_id_pc4_d   = pc_plus4_s;
            if_id_valid_d = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // State register with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC_ALIGNED;
            if_id_instr_q <= {INSTRUCTION_WIDTH{1'b0}};
            if_id_pc4_q   <= 32'd0;
            if_id_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
            fetch_fault_q <= fetch_fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.im_addr     = pc_q[IM_ADDRESS_WIDTH+1:2];
    assign bus.pc          = pc_q;
    assign bus.if_id_instr = if_id_instr_q;
    assign bus.if_id_pc4   = if_id_pc4_q;
    assign bus.if_id_valid = if_id_valid_q;
    assign bus.fetch_fault = fetch_fault_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed per-cycle vectors push the expected
// post-edge state into a queue; a monitor on the falling edge pops and compares.
module tb_instruction_fetch;

    logic clk;
    logic rst;

    instruction_fetch_if #(.IM_ADDRESS_WIDTH(6), .INSTRUCTION_WIDTH(32)) bus ();

    instruction_fetch #(
        .IM_ADDRESS_WIDTH (6),
        .INSTRUCTION_WIDTH(32),
        .RESET_PC         (32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Instruction memory model: combinational read.
    logic [31:0] im_mem [0:63];
    assign bus.im_q = im_mem[bus.im_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        fault;
        logic [31:0] count;
        logic        chk_pc4;
    } exp_t;

    exp_t exp_q [$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    endtask

    // Monitor: compare the registered outputs against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] e_addr;
            e = exp_q.pop_front();
            e_addr = {26'd0, e.pc[7:2]};
            chk("pc",          bus.pc,                  e.pc);
            chk("im_addr",     {26'd0, bus.im_addr},    e_addr);
            chk("if_id_instr", bus.if_id_instr,         e.instr);
            if (e.chk_pc4) chk("if_id_pc4", bus.if_id_pc4, e.pc4);
            chk("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, e.valid});
            chk("fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, e.fault});
            chk("fetch_count", bus.fetch_count,         e.count);
        end
    end

    // One clock of stimulus plus the state expected right after that edge.
    task automatic step(input logic r, input logic st, input logic rd, input logic [31:0] rpc,
                        input logic [31:0] e_pc, input logic [31:0] e_instr,
                        input logic [31:0] e_pc4, input logic e_valid,
                        input logic e_fault, input logic [31:0] e_cnt,
                        input logic e_chk_pc4);
        exp_t e;
        @(negedge clk);
        rst             = r;
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        @(posedge clk);
        #1;
        e.pc = e_pc; e.instr = e_instr; e.pc4 = e_pc4; e.valid = e_valid;
        e.fault = e_fault; e.count = e_cnt; e.chk_pc4 = e_chk_pc4;
        exp_q.push_back(e);
    endtask

    localparam logic [31:0] W0 = 32'h00A6_2020;
    localparam logic [31:0] W1 = 32'h00A6_2022;
    localparam logic [31:0] W2 = 32'h00A6_2023;
    localparam logic [31:0] W3 = 32'h20E8_FFF6;
    localparam logic [31:0] W4 = 32'h28E8_FFFE;
    localparam logic [31:0] W5 = 32'h0106_3824;
    localparam logic [31:0] W62 = 32'hC0DE_003E;
    localparam logic [31:0] W63 = 32'hC0DE_003F;

    initial begin
        logic [31:0] seq [0:5];
        seq[0] = W0; seq[1] = W1; seq[2] = W2; seq[3] = W3; seq[4] = W4; seq[5] = W5;
        for (int i = 0; i < 64; i++) im_mem[i] = {16'hC0DE, 16'(i)};
        for (int i = 0; i < 6; i++) im_mem[i] = seq[i];
        rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'd0;

        // Reset, then six sequential fetches.
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        for (int k = 1; k <= 6; k++)
            step(1'b0, 1'b0, 1'b0, 32'd0, 32'(4*k), seq[k-1], 32'(4*k), 1'b1, 1'b0, 32'(k), 1'b1);

        // Reset, advance to pc=8, stall three cycles, release.
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd4, W0, 32'd4, 1'b1, 1'b0, 32'd1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd8, W1, 32'd8, 1'b1, 1'b0, 32'd2, 1'b1);
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b1, 1'b0, 32'd0, 32'd8, W1, 32'd8, 1'b1, 1'b0, 32'd2, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd12, W2, 32'd12, 1'b1, 1'b0, 32'd3, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd16, W3, 32'd16, 1'b1, 1'b0, 32'd4, 1'b1);

        // Redirect to 0x13 while pc=16: one bubble, then word 4.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0013, 32'h10, 32'd0, 32'd0, 1'b0, 1'b0, 32'd4, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'h14, W4, 32'h14, 1'b1, 1'b0, 32'd5, 1'b1);

        // Redirect together with stall: redirect wins.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h08, 32'd0, 32'd0, 1'b0, 1'b0, 32'd5, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'h0C, W2, 32'h0C, 1'b1, 1'b0, 32'd6, 1'b1);

        // Run off the end of memory.
        step(1'b0, 1'b0, 1'b1, 32'h0000_00F8, 32'hF8, 32'd0, 32'd0, 1'b0, 1'b0, 32'd6, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'hFC, W62, 32'hFC, 1'b1, 1'b0, 32'd7, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'h100, W63, 32'h100, 1'b1, 1'b0, 32'd8, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'h100, 32'd0, 32'd0, 1'b0, 1'b1, 32'd8, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'h100, 32'd0, 32'd0, 1'b0, 1'b1, 32'd8, 1'b0);
        // Far out-of-range target also parks.
        step(1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 1'b1, 32'd8, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 1'b1, 32'd8, 1'b0);
        // Redirect to 0 resumes; fault stays set.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd8, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'h4, W0, 32'h4, 1'b1, 1'b1, 32'd9, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'h8, W1, 32'h8, 1'b1, 1'b1, 32'd10, 1'b1);

        // Reset with count=10, redirect and stall also high: reset wins.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'h4, W0, 32'h4, 1'b1, 1'b0, 32'd1, 1'b1);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total_cnt++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
